// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock byte FIFO with occupancy counter and full/empty flags
// FIFO_FWFT_EN selects first-word fall-through output instead of the registered read.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_en, rd_en;

  // Flags depend only on registered state, so rd/wr never reach them combinationally.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  always_comb begin
    wr_en    = wr && !full;
    rd_en    = rd && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (rd_en && !wr_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; contents are meaningless once count is 0.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_W-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (rd_en) data_out_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_out_q <= '0;
    else     data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo against a queue reference model
// Directed table, hand-written corner sequences and randomized traffic; FIFO_FWFT_EN aware.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr  = 1'b0;
  logic          rd  = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          empty, full;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] model_reg_dout = '0;

  sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd),
    .data_in(data_in), .data_out(data_out), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v_wr;
    logic          v_rd;
    logic [DW-1:0] v_din;
    logic [DW-1:0] e_dout;
    logic          e_empty;
    logic          e_full;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_dout();
`ifdef FIFO_FWFT_EN
    return (model_q.size() == 0) ? '0 : model_q[0];
`else
    return model_reg_dout;
`endif
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
    check({tag, ".dout"},  32'(data_out), 32'(model_dout()));
  endtask

  task automatic model_reset();
    model_q.delete();
    model_reg_dout = '0;
  endtask

  // Apply one cycle of inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    bit wa, ra;
    wr = w; rd = r; data_in = d;
    wa = w && (model_q.size() < DEPTH);
    ra = r && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (ra) model_reg_dout = model_q.pop_front();
    if (wa) model_q.push_back(d);
    wr = 1'b0; rd = 1'b0;
    check_model(tag);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.full",  32'(full),  32'd0);
    check("rst.dout",  32'(data_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] fill_vals [8];
    logic [DW-1:0] cnt;
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};

    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 1'b0, fill_vals[i], 8'h00, 1'b0, (i == 7)};
    vecs[8] = '{1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++)
      vecs[9 + i] = '{1'b0, 1'b1, 8'h00, fill_vals[i], (i == 7), 1'b0};
    vecs[17] = '{1'b0, 1'b1, 8'h00, 8'h44, 1'b1, 1'b0};

    // Reset asserted from time zero, no clock edge yet.
    #1;
    check("init.empty", 32'(empty), 32'd1);
    check("init.full",  32'(full),  32'd0);
    check("init.dout",  32'(data_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Dirty the state, then check that reset acts between edges.
    step(1'b1, 1'b0, 8'h77, "pre");
    step(1'b1, 1'b0, 8'h78, "pre");
    step(1'b0, 1'b1, 8'h00, "pre");
    async_reset();

`ifndef FIFO_FWFT_EN
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].v_wr, vecs[i].v_rd, vecs[i].v_din, $sformatf("vec%0d", i));
      check($sformatf("tab%0d.empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("tab%0d.full", i),  32'(full),  32'(vecs[i].e_full));
      check($sformatf("tab%0d.dout", i),  32'(data_out), 32'(vecs[i].e_dout));
    end
`else
    step(1'b1, 1'b0, 8'h11, "fwft");
    check("fwft.head", 32'(data_out), 32'h11);
    step(1'b0, 1'b1, 8'h00, "fwft");
    check("fwft.empty", 32'(empty), 32'd1);
    check("fwft.zero",  32'(data_out), 32'd0);
`endif

    // rd&wr while empty: only the write lands.
    step(1'b1, 1'b1, 8'h90, "sim_empty");
    check("sim_empty.notempty", 32'(empty), 32'd0);
    step(1'b1, 1'b0, 8'h91, "wrap_fill");
    step(1'b1, 1'b0, 8'h92, "wrap_fill");
    cnt = 8'h93;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, cnt, "wrap");
      cnt++;
    end
`ifndef FIFO_FWFT_EN
    check("wrap.last_out", 32'(data_out), 32'h99);
`endif
    check("wrap.count", 32'(model_q.size()), 32'd3);

    // Fill, then rd&wr while full: only the read lands.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hc0 + 8'(i), "fill2");
    check("fill2.full", 32'(full), 32'd1);
    step(1'b1, 1'b1, 8'hee, "sim_full");
    check("sim_full.notfull", 32'(full), 32'd0);

    // Five entries stored, then reset mid-stream.
    while (model_q.size() > 5) step(1'b0, 1'b1, 8'h00, "trim");
    async_reset();
    step(1'b1, 1'b0, 8'ha5, "post_rst");
    step(1'b0, 1'b1, 8'h00, "post_rst");
    check("post_rst.dout", 32'(data_out), 32'ha5);
    check("post_rst.empty", 32'(empty), 32'd1);

    // Randomized traffic with phases biased toward fill, drain and balance.
    for (int i = 0; i < 3000; i++) begin
      int ph;
      logic w, r;
      ph = (i / 300) % 3;
      w = ($urandom_range(0, 99) < (ph == 0 ? 80 : ph == 1 ? 20 : 50));
      r = ($urandom_range(0, 99) < (ph == 0 ? 20 : ph == 1 ? 80 : 50));
      step(w, r, 8'($urandom), "rand");
      if (i == 1500) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
